// File: rtl/vend_pkg.sv
// Shared constants and types for the change dispenser: coin values, FSM states
// and the one-hot coin select.
package vend_pkg;

    localparam int COIN_5  = 5;
    localparam int COIN_10 = 10;
    localparam int COIN_25 = 25;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT_WAIT,
        DONE,
        FAULT
    } chg_state_t;

    typedef struct packed {
        logic c25;
        logic c10;
        logic c5;
    } coin_sel_t;

    function automatic int coin_value(input coin_sel_t c);
        return c.c25 ? COIN_25 : c.c10 ? COIN_10 : c.c5 ? COIN_5 : 0;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Vending-side and hopper-side signals of the change dispenser.
// low_change exists only when COIN_INVENTORY_EN is defined.
interface change_dispenser_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] credit;
    logic [WIDTH-1:0] price;
    logic             hopper_ack;
    logic             eject_25;
    logic             eject_10;
    logic             eject_5;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] change_left;
    logic             underflow;
    logic             fault;

`ifdef COIN_INVENTORY_EN
    logic [2:0]       low_change;

    modport slave (
        input  start, credit, price, hopper_ack,
        output eject_25, eject_10, eject_5, busy, done, change_left, underflow, fault, low_change
    );
    modport master (
        output start, credit, price, hopper_ack,
        input  eject_25, eject_10, eject_5, busy, done, change_left, underflow, fault, low_change
    );
`else
    modport slave (
        input  start, credit, price, hopper_ack,
        output eject_25, eject_10, eject_5, busy, done, change_left, underflow, fault
    );
    modport master (
        output start, credit, price, hopper_ack,
        input  eject_25, eject_10, eject_5, busy, done, change_left, underflow, fault
    );
`endif

endinterface

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse on the cycle din goes from 0 to 1.
module edge_detector (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) din_q <= 1'b0;
        else          din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/change_dispenser.sv
// Pays out credit-price largest coin first (25/10/5), one eject per hopper ack.
// COIN_INVENTORY_EN adds per-denomination stock counters and low_change flags.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int WIDTH       = 8,
`ifdef COIN_INVENTORY_EN
    parameter int INV_W       = 6,
    parameter int INIT_INV    = 20,
`endif
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    change_dispenser_if.slave  bus
);

    localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    chg_state_t       state, state_nx;
    logic [WIDTH-1:0] left_q, left_nx;
    logic             armed_q, armed_nx;
    coin_sel_t        coin_q, coin_nx;
    coin_sel_t        eject_q, eject_nx;
    logic [TW-1:0]    tmr_q, tmr_nx;
    logic             ack_rise;
    coin_sel_t        avail;
    coin_sel_t        pick;

    edge_detector u_ack_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.hopper_ack),
        .rise    (ack_rise)
    );

`ifdef COIN_INVENTORY_EN
    logic [2:0][INV_W-1:0] inv_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inv_q <= {3{INV_W'(INIT_INV)}};
        end else if (state == EJECT_WAIT && ack_rise) begin
            if (coin_q.c25) inv_q[2] <= inv_q[2] - INV_W'(1);
            if (coin_q.c10) inv_q[1] <= inv_q[1] - INV_W'(1);
            if (coin_q.c5)  inv_q[0] <= inv_q[0] - INV_W'(1);
        end
    end

    assign avail.c25      = (inv_q[2] != '0);
    assign avail.c10      = (inv_q[1] != '0);
    assign avail.c5       = (inv_q[0] != '0);
    assign bus.low_change = {~avail.c25, ~avail.c10, ~avail.c5};
`else
    assign avail = coin_sel_t'(3'b111);
`endif

    // Largest stocked coin that still fits in the remaining change.
    always_comb begin
        pick = '0;
        if (avail.c25 && left_q >= WIDTH'(COIN_25))      pick.c25 = 1'b1;
        else if (avail.c10 && left_q >= WIDTH'(COIN_10)) pick.c10 = 1'b1;
        else if (avail.c5 && left_q >= WIDTH'(COIN_5))   pick.c5  = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            left_q  <= '0;
            armed_q <= 1'b0;
            coin_q  <= '0;
            eject_q <= '0;
            tmr_q   <= '0;
        end else begin
            state   <= state_nx;
            left_q  <= left_nx;
            armed_q <= armed_nx;
            coin_q  <= coin_nx;
            eject_q <= eject_nx;
            tmr_q   <= tmr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        left_nx  = left_q;
        armed_nx = armed_q;
        coin_nx  = coin_q;
        eject_nx = '0;
        tmr_nx   = tmr_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = SELECT;
                    if (bus.credit >= bus.price) begin
                        left_nx  = bus.credit - bus.price;
                        armed_nx = 1'b0;
                    end else begin
                        left_nx  = '0;
                        armed_nx = 1'b1;
                    end
                end
            end
            SELECT: begin
                if (pick != '0) begin
                    coin_nx  = pick;
                    eject_nx = pick;
                    tmr_nx   = '0;
                    state_nx = EJECT_WAIT;
                end else begin
                    state_nx = DONE;
                end
            end
            EJECT_WAIT: begin
                // An ack edge on the last timer cycle still counts.
                if (ack_rise) begin
                    left_nx  = left_q - WIDTH'(coin_value(coin_q));
                    state_nx = SELECT;
                end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_nx = FAULT;
                end else begin
                    tmr_nx = tmr_q + TW'(1);
                end
            end
            DONE: begin
                armed_nx = 1'b0;
                state_nx = IDLE;
            end
            FAULT:   state_nx = FAULT;
            default: state_nx = IDLE;
        endcase
    end

    // Eject is registered so it lines up with the first EJECT_WAIT cycle.
    assign bus.eject_25    = eject_q.c25;
    assign bus.eject_10    = eject_q.c10;
    assign bus.eject_5     = eject_q.c5;
    assign bus.busy        = (state == SELECT) || (state == EJECT_WAIT);
    assign bus.done        = (state == DONE);
    assign bus.underflow   = (state == DONE) && armed_q;
    assign bus.fault       = (state == FAULT);
    assign bus.change_left = left_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser with a coin-list reference model,
// per-cycle output comparison and a few hand-computed directed cases.
module tb_change_dispenser;

    localparam int W    = 8;
    localparam int AT   = 40;
    localparam int INIT = 20;

    logic clk = 1'b0;
    logic reset_n;

    change_dispenser_if #(.WIDTH(W)) bus ();

    change_dispenser #(.WIDTH(W), .ACK_TIMEOUT(AT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // reference model: pending coin list plus the cycle the next event is due
    int coins[$];
    int inv[3];
    int m_left, m_due, m_dl, m_cur, m_phase;
    bit m_active, m_under, m_fault;

    // observations of the DUT for the directed literal checks
    int log_q[$];
    int lat, done_left, done_under, n_st, n_ej, n_flt;
    int pend;
    bit mute;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic int enc(input int v);
        return (v == 25) ? 4 : (v == 10) ? 2 : (v == 5) ? 1 : 0;
    endfunction

    function automatic int dec(input int e);
        return (e == 4) ? 25 : (e == 2) ? 10 : (e == 1) ? 5 : -1;
    endfunction

    function automatic void plan(input int chg);
        int c, k25, k10, k5;
        c = chg;
`ifdef COIN_INVENTORY_EN
        k25 = inv[2]; k10 = inv[1]; k5 = inv[0];
`else
        k25 = 1000; k10 = 1000; k5 = 1000;
`endif
        coins.delete();
        while (c >= 5) begin
            if (c >= 25 && k25 > 0)      begin coins.push_back(25); c -= 25; k25--; end
            else if (c >= 10 && k10 > 0) begin coins.push_back(10); c -= 10; k10--; end
            else if (k5 > 0)             begin coins.push_back(5);  c -= 5;  k5--;  end
            else break;
        end
    endfunction

    function automatic void model_reset();
        m_left = 0; m_phase = 0; m_active = 0; m_under = 0; m_fault = 0;
        coins.delete();
        for (int i = 0; i < 3; i++) inv[i] = INIT;
    endfunction

    // per-cycle compare against the model, then advance the model
    initial begin : cmp
        int n, got_ej, exp_ej;
        bit ack_prev, ack_rise, exp_done;
        n = 0; ack_prev = 0; pend = 0;
        model_reset();
        forever begin
            @(negedge clk);
            n++;
            got_ej = {29'd0, bus.eject_25, bus.eject_10, bus.eject_5};
            if (!reset_n) begin
                chk("reset_outs", {got_ej[2:0], bus.busy, bus.done, bus.underflow, bus.fault, bus.change_left}, 0);
                model_reset();
                ack_prev = 0;
            end else begin
                ack_rise = bus.hopper_ack && !ack_prev;
                ack_prev = bus.hopper_ack;
                exp_ej = 0; exp_done = 0;
                if (m_phase == 1 && n == m_due) begin
                    if (coins.size() > 0) exp_ej = enc(coins[0]);
                    else exp_done = 1;
                end
                chk("eject", got_ej, exp_ej);
                chk("done", bus.done, exp_done);
                chk("busy", bus.busy, m_active && !exp_done);
                chk("underflow", bus.underflow, exp_done && m_under);
                chk("fault", bus.fault, m_fault);
                chk("change_left", bus.change_left, m_left);
`ifdef COIN_INVENTORY_EN
                chk("low_change", bus.low_change, {inv[2] == 0, inv[1] == 0, inv[0] == 0});
`endif
                if (got_ej != 0) begin
                    log_q.push_back(dec(got_ej));
                    n_ej = n;
                    pend++;
                    if (lat < 0) lat = n - n_st;
                end
                if (bus.done) begin
                    if (lat < 0) lat = n - n_st;
                    done_left  = bus.change_left;
                    done_under = bus.underflow;
                end
                if (bus.fault && n_flt < 0) n_flt = n;

                if (bus.start && !m_active && !m_fault) begin
                    m_active = 1; m_phase = 1; m_due = n + 2; n_st = n; lat = -1;
                    if (bus.credit >= bus.price) begin
                        m_left = bus.credit - bus.price; m_under = 0;
                    end else begin
                        m_left = 0; m_under = 1;
                    end
                    plan(m_left);
                end
                if (m_phase == 1 && n == m_due) begin
                    if (coins.size() > 0) begin
                        m_cur = coins.pop_front(); m_phase = 2; m_dl = n + AT - 1;
                    end else begin
                        m_phase = 0; m_active = 0; m_under = 0;
                    end
                end
                if (m_phase == 2) begin
                    if (ack_rise) begin
                        m_left -= m_cur;
                        if (m_cur == 25) inv[2]--;
                        else if (m_cur == 10) inv[1]--;
                        else inv[0]--;
                        m_phase = 1; m_due = n + 2;
                    end else if (n == m_dl) begin
                        m_phase = 0; m_active = 0; m_fault = 1;
                    end
                end
            end
        end
    end

    // hopper: acks each eject after a random delay, holding ack 1..3 cycles
    initial begin : hopper
        int dly, hold;
        dly = 0; hold = 0; bus.hopper_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n || mute) begin
                bus.hopper_ack = 1'b0; dly = 0; hold = 0; pend = 0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) bus.hopper_ack = 1'b0;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin bus.hopper_ack = 1'b1; hold = $urandom_range(1, 3); end
            end else if (pend > 0) begin
                pend--; dly = $urandom_range(1, 6);
            end
        end
    end

    task automatic pulse(input int cr, input int pr);
        log_q.delete();
        done_left = -1; done_under = -1; n_flt = -1;
        @(posedge clk); #1;
        bus.credit = W'(cr); bus.price = W'(pr); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.credit = W'($urandom); bus.price = W'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((m_active || bus.busy) && k < 3000) begin @(negedge clk); k++; end
        if (k >= 3000) chk(name, k, 0);
    endtask

    task automatic txn(input int cr, input int pr);
        pulse(cr, pr);
        wait_idle("txn_timeout");
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin : drive
        int k, cr, pr;
        reset_n = 1'b0; mute = 1'b0;
        bus.start = 1'b0; bus.credit = '0; bus.price = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        txn(90, 50);
        chk("t1_ncoins", log_q.size(), 3);
        chk("t1_c0", log_q[0], 25);
        chk("t1_c1", log_q[1], 10);
        chk("t1_c2", log_q[2], 5);
        chk("t1_latency", lat, 2);
        chk("t1_left", done_left, 0);

        txn(50, 50);
        chk("t2_ncoins", log_q.size(), 0);
        chk("t2_latency", lat, 2);
        chk("t2_left", done_left, 0);

        txn(33, 25);
        chk("t3_ncoins", log_q.size(), 1);
        chk("t3_c0", log_q[0], 5);
        chk("t3_left", done_left, 3);

        txn(20, 25);
        chk("t4_ncoins", log_q.size(), 0);
        chk("t4_underflow", done_under, 1);
        chk("t4_left", done_left, 0);

        mute = 1'b1;
        pulse(60, 35);
        k = 0;
        while (!m_fault && k < 200) begin @(negedge clk); k++; end
        @(negedge clk);
        chk("t5_fault_latency", n_flt - n_ej, AT);
        pulse(90, 50);
        repeat (5) @(negedge clk);
        chk("t5_start_ignored", bus.busy, 0);
        chk("t5_sticky", bus.fault, 1);
        do_reset();
        @(negedge clk);
        chk("t5_cleared", bus.fault, 0);

        pulse(100, 0);
        k = 0;
        while (log_q.size() == 0 && k < 20) begin @(negedge clk); k++; end
        chk("t6_eject_seen", log_q.size(), 1);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("t6_async_reset", {bus.eject_25, bus.eject_10, bus.eject_5, bus.busy, bus.done, bus.fault, bus.change_left}, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        mute = 1'b0;

`ifdef COIN_INVENTORY_EN
        txn(250, 0);
        txn(250, 0);
        txn(25, 0);
        chk("t6_inv_ncoins", log_q.size(), 3);
        chk("t6_inv_c0", log_q[0], 10);
        chk("t6_inv_c1", log_q[1], 10);
        chk("t6_inv_c2", log_q[2], 5);
        chk("t6_low_change", bus.low_change, 4);
`endif

        for (int i = 0; i < 40; i++) begin
            cr = $urandom_range(0, 255);
            pr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, cr);
            pulse(cr, pr);
            if ($urandom_range(0, 3) == 0) begin
                repeat (3) @(posedge clk);
                #1 bus.start = 1'b1; bus.credit = W'($urandom); bus.price = W'($urandom);
                @(posedge clk);
                #1 bus.start = 1'b0;
            end
            wait_idle("rand_timeout");
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
